multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port halt, input, 1 bit; while high, no new fetch is issued.
REQ-005 The block SHALL have port imem_ack, input, 1 bit, the instruction-memory completion strobe.
REQ-006 The block SHALL have port dmem_ack, input, 1 bit, the data-memory completion strobe.
REQ-007 The block SHALL have ports is_r, is_i, is_l, is_s, is_b, is_j, is_jr, is_lui and is_auipc, input, 1 bit each: instruction-class flags decoded from the instruction register (IR).
REQ-008 The block SHALL have port rd_valid, input, 1 bit, high when the decoded instruction writes rd.
REQ-009 The block SHALL have port br_taken, input, 1 bit, the branch comparison result, valid in EXEC.
REQ-010 The block SHALL have port imem_req, output, 1 bit, the instruction-fetch request.
REQ-011 The block SHALL have port ir_we, output, 1 bit, the IR load strobe.
REQ-012 The block SHALL have port dmem_req, output, 1 bit, the data-access request.
REQ-013 The block SHALL have port dmem_we, output, 1 bit; 1 selects store, 0 selects load.
REQ-014 The block SHALL have port rf_we, output, 1 bit, the register-file write strobe.
REQ-015 The block SHALL have port pc_we, output, 1 bit, the PC update strobe.
REQ-016 The block SHALL have port pc_sel, output, 2 bits, the next-PC source: 0 = PC+4, 1 = branch target, 2 = JAL target, 3 = JALR target.
REQ-017 The block SHALL have port state, output, 3 bits, the current FSM state.
REQ-018 The block SHALL have port illegal, output, 1 bit, the sticky illegal-instruction flag.
REQ-019 The block SHALL have port instret, output, CNT_W bits, the retired-instruction count.

Function
REQ-020 The FSM SHALL use the state encodings FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5; codes 6 and 7 SHALL transition to TRAP.
REQ-021 In FETCH, imem_req SHALL equal !halt.
- On imem_req && imem_ack: ir_we = 1 for exactly that cycle, then go to DECODE.
- Otherwise remain in FETCH.
- imem_ack while halt = 1 SHALL be ignored.
REQ-022 In DECODE, the FSM SHALL spend one cycle and go to EXEC if any class flag is high, else to TRAP.
REQ-023 Class priority SHALL be jr > j > b > s > l > r > i > lui > auipc, because is_i and is_jr may both be high.
REQ-024 EXEC SHALL take one cycle.
- b: pc_we = 1, pc_sel = br_taken ? 1 : 0, go to FETCH.
- s or l: go to MEM.
- All other classes: go to WB.
REQ-025 In MEM, dmem_req SHALL be 1 and dmem_we SHALL equal is_s, both held until dmem_ack.
- On dmem_ack for l: go to WB.
- On dmem_ack for s: pc_we = 1, pc_sel = 0, go to FETCH.
REQ-026 WB SHALL take one cycle and then go to FETCH.
- rf_we = rd_valid.
- pc_we = 1.
- pc_sel = 2 for j, 3 for jr, else 0.
REQ-027 In TRAP, all strobes SHALL be 0 and illegal SHALL be 1; TRAP is left only by reset.
REQ-028 instret SHALL increment by 1 on every cycle with pc_we = 1 and wrap modulo 2^CNT_W.
REQ-029 Strobes SHALL be decoded from state, so each of ir_we, rf_we and pc_we is high for at most one cycle per instruction.
REQ-030 An ack arriving while its request is low SHALL have no effect.
REQ-031 Cycles per instruction with zero-wait acks SHALL be: branch 3, ALU/jump 4, store 4, load 5.

Reset
REQ-032 While rst_n = 0, the following SHALL hold immediately, independent of clk:
- state = FETCH.
- imem_req, ir_we, dmem_req, dmem_we, rf_we and pc_we = 0.
- pc_sel = 0, illegal = 0, instret = 0.
REQ-033 Reset asserted mid-access (MEM or FETCH) SHALL abandon the access; after rst_n rises, the first edge evaluates FETCH with halt.
REQ-034 No output SHALL be X after reset.

Verification
REQ-035 The bench SHALL cover: R-type with acks tied to 1 -> states 0,1,2,4,0; rf_we and pc_we each high 1 cycle with pc_sel = 0; instret 0 -> 1.
REQ-036 The bench SHALL cover: load with dmem_ack delayed 3 cycles -> dmem_req = 1 and dmem_we = 0 for 4 cycles, then WB with rf_we = 1; total 8 cycles; instret = 1.
REQ-037 The bench SHALL cover: branch with br_taken = 1, then br_taken = 0 -> pc_sel = 1 then 0; rf_we never asserted; 3 cycles each.
REQ-038 The bench SHALL cover: is_i = is_jr = 1 -> WB with pc_sel = 3 (JALR priority); store -> dmem_we = 1, no WB, pc_sel = 0.
REQ-039 The bench SHALL cover: all class flags 0 -> TRAP after DECODE; illegal = 1 held for 20 cycles despite acks; rst_n pulse clears illegal and instret to 0.
REQ-040 The bench SHALL cover: halt = 1 with imem_ack = 1 -> imem_req = 0 and no ir_we; rst_n dropped during MEM wait -> outputs cleared asynchronously before the next clk edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, memory and write-back,
// drives datapath strobes from the current state and counts retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             is_r,
    input  logic             is_i,
    input  logic             is_l,
    input  logic             is_s,
    input  logic             is_b,
    input  logic             is_j,
    input  logic             is_jr,
    input  logic             is_lui,
    input  logic             is_auipc,
    input  logic             rd_valid,
    input  logic             br_taken,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NONE  = 4'd0,
        C_JR    = 4'd1,
        C_J     = 4'd2,
        C_B     = 4'd3,
        C_S     = 4'd4,
        C_L     = 4'd5,
        C_R     = 4'd6,
        C_I     = 4'd7,
        C_LUI   = 4'd8,
        C_AUIPC = 4'd9
    } cls_t;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_JAL   = 2'd2;
    localparam logic [1:0] PC_JALR  = 2'd3;

    state_t            state_q, state_d;
    cls_t              cls_q, cls_d;
    cls_t              dec_cls;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic              imem_req_c;
    logic              ir_we_c;
    logic              dmem_req_c;
    logic              dmem_we_c;
    logic              rf_we_c;
    logic              pc_we_c;
    logic [1:0]        pc_sel_c;
    logic              illegal_c;

    // is_i and is_jr can both be set for JALR, so the priority order matters.
    always_comb begin
        if (is_jr)         dec_cls = C_JR;
        else if (is_j)     dec_cls = C_J;
        else if (is_b)     dec_cls = C_B;
        else if (is_s)     dec_cls = C_S;
        else if (is_l)     dec_cls = C_L;
        else if (is_r)     dec_cls = C_R;
        else if (is_i)     dec_cls = C_I;
        else if (is_lui)   dec_cls = C_LUI;
        else if (is_auipc) dec_cls = C_AUIPC;
        else               dec_cls = C_NONE;
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        rf_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = PC_PLUS4;
        illegal_c  = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req_c = !halt;
                if (!halt && imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d   = dec_cls;
                state_d = (dec_cls == C_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_B: begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = br_taken ? PC_BR : PC_PLUS4;
                        state_d  = S_FETCH;
                    end
                    C_S, C_L: state_d = S_MEM;
                    default:  state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls_q == C_S);
                if (dmem_ack) begin
                    if (cls_q == C_S) begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c = rd_valid;
                pc_we_c = 1'b1;
                if (cls_q == C_J)       pc_sel_c = PC_JAL;
                else if (cls_q == C_JR) pc_sel_c = PC_JALR;
                else                    pc_sel_c = PC_PLUS4;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                illegal_c = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    always_comb begin
        instret_d = instret_q;
        if (pc_we_c) instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            instret_q <= instret_d;
        end
    end

    // FETCH would otherwise raise imem_req during reset, so every strobe is gated by rst_n.
    assign imem_req = rst_n & imem_req_c;
    assign ir_we    = rst_n & ir_we_c;
    assign dmem_req = rst_n & dmem_req_c;
    assign dmem_we  = rst_n & dmem_we_c;
    assign rf_we    = rst_n & rf_we_c;
    assign pc_we    = rst_n & pc_we_c;
    assign pc_sel   = rst_n ? pc_sel_c : PC_PLUS4;
    assign illegal  = rst_n & illegal_c;
    assign state    = state_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of instructions checked against expected state
// sequences and strobe counts, plus hand-written halt, trap and reset sequences.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             halt, imem_ack, dmem_ack;
    logic             is_r, is_i, is_l, is_s, is_b, is_j, is_jr, is_lui, is_auipc;
    logic             rd_valid, br_taken;
    logic             imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
    logic [1:0]       pc_sel;
    logic [2:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]       exp_q[$];
    logic [CNT_W-1:0] exp_instret;

    // flags order: {r, i, l, s, b, j, jr, lui, auipc}
    typedef struct {
        logic [8:0] flags;
        logic       rd;
        logic       br;
        int         dly;
        int         cyc;
        logic [1:0] pcsel;
        int         rf;
        int         mem;
        logic       dwe;
    } vec_t;

    vec_t vecs[$];

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .halt     (halt),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .is_r     (is_r),
        .is_i     (is_i),
        .is_l     (is_l),
        .is_s     (is_s),
        .is_b     (is_b),
        .is_j     (is_j),
        .is_jr    (is_jr),
        .is_lui   (is_lui),
        .is_auipc (is_auipc),
        .rd_valid (rd_valid),
        .br_taken (br_taken),
        .imem_req (imem_req),
        .ir_we    (ir_we),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .rf_we    (rf_we),
        .pc_we    (pc_we),
        .pc_sel   (pc_sel),
        .state    (state),
        .illegal  (illegal),
        .instret  (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_flags(input logic [8:0] f);
        {is_r, is_i, is_l, is_s, is_b, is_j, is_jr, is_lui, is_auipc} = f;
    endtask

    function automatic logic [9:0] outs();
        return {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, illegal, 1'b0};
    endfunction

    function automatic vec_t mk(logic [8:0] f, logic rd, logic br, int dly, int cyc,
                                logic [1:0] pcsel, int rf, int mem, logic dwe);
        vec_t v;
        v.flags = f; v.rd = rd; v.br = br; v.dly = dly; v.cyc = cyc;
        v.pcsel = pcsel; v.rf = rf; v.mem = mem; v.dwe = dwe;
        return v;
    endfunction

    task automatic run_instr(input int idx, input vec_t v);
        int n_ir, n_pc, n_rf, n_req, n_we, mem_cnt;
        logic [1:0] sel_seen;
        logic [2:0] exp_s;
        n_ir = 0; n_pc = 0; n_rf = 0; n_req = 0; n_we = 0; mem_cnt = 0;
        sel_seen = 2'bxx;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        for (int k = 0; k < v.mem; k++) exp_q.push_back(3'd3);
        if (v.cyc == 3 + v.mem + 1) exp_q.push_back(3'd4);
        for (int c = 0; c < v.cyc; c++) begin
            @(negedge clk);
            halt     = 1'b0;
            imem_ack = 1'b1;
            set_flags(v.flags);
            rd_valid = v.rd;
            br_taken = v.br;
            dmem_ack = dmem_req && (mem_cnt == v.dly);
            #1;
            exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd7;
            chk($sformatf("v%0d_state_c%0d", idx, c), state, exp_s);
            if (ir_we) n_ir++;
            if (rf_we) n_rf++;
            if (dmem_req) begin
                n_req++;
                mem_cnt++;
                if (dmem_we) n_we++;
            end
            if (pc_we) begin
                n_pc++;
                sel_seen = pc_sel;
            end
        end
        chk($sformatf("v%0d_ir_we_cnt", idx), n_ir, 1);
        chk($sformatf("v%0d_pc_we_cnt", idx), n_pc, 1);
        chk($sformatf("v%0d_rf_we_cnt", idx), n_rf, v.rf);
        chk($sformatf("v%0d_pc_sel", idx), {30'd0, sel_seen}, {30'd0, v.pcsel});
        chk($sformatf("v%0d_dmem_req_cnt", idx), n_req, v.mem);
        chk($sformatf("v%0d_dmem_we_cnt", idx), n_we, v.dwe ? v.mem : 0);
        exp_instret = exp_instret + 1'b1;
        // Park in FETCH with halt high; the pending imem_ack must be ignored.
        @(negedge clk);
        halt     = 1'b1;
        dmem_ack = 1'b0;
        #1;
        chk($sformatf("v%0d_end_state", idx), state, 3'd0);
        chk($sformatf("v%0d_end_halt_req", idx), {imem_req, ir_we}, 2'b00);
        chk($sformatf("v%0d_instret", idx), instret, exp_instret);
    endtask

    initial begin
        int d;
        logic found;

        // {r,i,l,s,b,j,jr,lui,auipc}
        vecs.push_back(mk(9'b100000000, 1, 0, 0, 4, 2'd0, 1, 0, 0)); // R-type
        vecs.push_back(mk(9'b001000000, 1, 0, 3, 8, 2'd0, 1, 4, 0)); // load, ack after 3
        vecs.push_back(mk(9'b000010000, 1, 1, 0, 3, 2'd1, 0, 0, 0)); // branch taken
        vecs.push_back(mk(9'b000010000, 1, 0, 0, 3, 2'd0, 0, 0, 0)); // branch not taken
        vecs.push_back(mk(9'b010000100, 1, 0, 0, 4, 2'd3, 1, 0, 0)); // i+jr -> JALR
        vecs.push_back(mk(9'b000100000, 1, 0, 0, 4, 2'd0, 0, 1, 1)); // store
        vecs.push_back(mk(9'b000001000, 1, 0, 0, 4, 2'd2, 1, 0, 0)); // jal
        vecs.push_back(mk(9'b000000010, 0, 0, 0, 4, 2'd0, 0, 0, 0)); // lui, no rd
        vecs.push_back(mk(9'b000000001, 1, 0, 0, 4, 2'd0, 1, 0, 0)); // auipc
        vecs.push_back(mk(9'b001000000, 1, 0, 0, 5, 2'd0, 1, 1, 0)); // load, zero wait
        vecs.push_back(mk(9'b000100000, 0, 0, 2, 6, 2'd0, 0, 3, 1)); // store, ack after 2
        vecs.push_back(mk(9'b000110000, 1, 1, 0, 3, 2'd1, 0, 0, 0)); // b beats s
        vecs.push_back(mk(9'b000001100, 1, 0, 0, 4, 2'd3, 1, 0, 0)); // jr beats j
        vecs.push_back(mk(9'b010000000, 1, 0, 0, 4, 2'd0, 1, 0, 0)); // i-type
        vecs.push_back(mk(9'b101000000, 1, 0, 1, 6, 2'd0, 1, 2, 0)); // l beats r
        for (int k = 0; k < 2; k++) begin
            d = $urandom_range(0, 4);
            vecs.push_back(mk(9'b001000000, 1, 0, d, 4 + d + 1, 2'd0, 1, d + 1, 0));
            d = $urandom_range(0, 4);
            vecs.push_back(mk(9'b000100000, 1, 0, d, 3 + d + 1, 2'd0, 0, d + 1, 1));
        end

        // Reset with halt low and acks high: all outputs must still read zero.
        rst_n = 1'b0; halt = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
        set_flags(9'b100000000); rd_valid = 1'b1; br_taken = 1'b1;
        exp_instret = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", state, 3'd0);
        chk("reset_outs", outs(), 10'd0);
        chk("reset_instret", instret, 0);
        halt = 1'b1; dmem_ack = 1'b0;
        rst_n = 1'b1;

        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk($sformatf("halt_c%0d", c), {state, imem_req, ir_we}, 5'd0);
        end

        for (int i = 0; i < vecs.size(); i++) run_instr(i, vecs[i]);

        // Illegal instruction: DECODE with no class flag goes to TRAP and stays.
        @(negedge clk);
        halt = 1'b0; imem_ack = 1'b1; set_flags(9'd0);
        #1;
        chk("trap_fetch", {state, ir_we}, {3'd0, 1'b1});
        @(negedge clk); #1;
        chk("trap_decode", state, 3'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            dmem_ack = 1'b1; br_taken = c[0];
            #1;
            chk($sformatf("trap_c%0d", c), {state, outs()}, {3'd5, 10'b0000000010});
        end
        chk("trap_instret", instret, exp_instret);
        @(negedge clk); #1;
        rst_n = 1'b0; dmem_ack = 1'b0;
        #1;
        chk("trap_reset_illegal", illegal, 1'b0);
        chk("trap_reset_state", state, 3'd0);
        chk("trap_reset_instret", instret, 0);
        exp_instret = '0;

        // Reset dropped while a load waits in MEM.
        @(negedge clk); #1;
        halt = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b0;
        set_flags(9'b001000000);
        rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (state == 3'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("mem_reached", found, 1'b1);
        @(negedge clk); #1;
        chk("mem_wait", {dmem_req, dmem_we, state}, {1'b1, 1'b0, 3'd3});
        rst_n = 1'b0;
        #1;
        chk("mem_async_reset_outs", outs(), 10'd0);
        chk("mem_async_reset_state", state, 3'd0);
        set_flags(9'b000010000); br_taken = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_fetch", {state, imem_req}, {3'd0, 1'b1});
        @(negedge clk); #1;
        chk("post_reset_decode", state, 3'd1);
        @(negedge clk); #1;
        chk("post_reset_exec", {state, pc_we, pc_sel}, {3'd2, 1'b1, 2'd0});
        halt = 1'b1;
        @(negedge clk); #1;
        chk("post_reset_instret", {state, instret}, {3'd0, 4'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
